// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: load funct3 encodings and the write-back slot record shared by the WB stage.
package riscv_wb_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int XLEN_MAX = 64;
  localparam int CH_ID_MAX_W = 3;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LD = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0] inst;
    logic [XLEN_MAX-1:0] data;
    logic [4:0] rd;
    logic wr_en;
    logic [CH_ID_MAX_W-1:0] ch_id;
  } wb_slot_t;
endpackage

// File: rtl/riscv_wb_load_fmt.sv
// riscv_wb_load_fmt: combinational load byte/half/word extraction and extension.
// RISCV_WB_LOAD_ALIGN_EN enables formatting; otherwise data passes straight through.
module riscv_wb_load_fmt
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic            is_load,
  output logic [XLEN-1:0] fmt
);
`ifdef RISCV_WB_LOAD_ALIGN_EN
  logic [2:0] lo;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] w;
  // RV32 has no doubleword lane, so addr_lo[2] never selects
  assign lo = (XLEN == 32) ? {1'b0, addr_lo[1:0]} : addr_lo;
  assign b = 8'(data >> {lo, 3'b000});
  assign h = 16'(data >> {lo[2:1], 4'b0000});
  assign w = 32'(data >> {lo[2], 5'b00000});
  always_comb
    fmt = !is_load                         ? data :
          funct3 == F3_LB                  ? XLEN'($signed(b)) :
          funct3 == F3_LBU                 ? XLEN'(b) :
          funct3 == F3_LH                  ? XLEN'($signed(h)) :
          funct3 == F3_LHU                 ? XLEN'(h) :
          funct3 == F3_LW                  ? XLEN'($signed(w)) :
          funct3 == F3_LWU && XLEN != 32   ? XLEN'(w) :
                                             data;
`else
  logic unused_fmt;
  assign unused_fmt = ^{funct3, addr_lo, is_load};
  assign fmt = data;
`endif
endmodule

// File: rtl/riscv_wb_stage_mc.sv
// riscv_wb_stage_mc: multi-channel round-robin write-back slot with load formatting.
// Load formatting is compiled in only with RISCV_WB_LOAD_ALIGN_EN defined.
module riscv_wb_stage_mc
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NUM_CH = 2,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_CH-1:0]             ch_valid,
  output logic [NUM_CH-1:0]             ch_ready,
  input  logic [NUM_CH-1:0][XLEN-1:0]   ch_pc,
  input  logic [NUM_CH-1:0][31:0]       ch_inst,
  input  logic [NUM_CH-1:0][XLEN-1:0]   ch_data,
  input  logic [NUM_CH-1:0][4:0]        ch_rd_addr,
  input  logic [NUM_CH-1:0]             ch_is_load,
  input  logic [NUM_CH-1:0][2:0]        ch_addr_lo,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [XLEN-1:0]               wb_pc,
  output logic [31:0]                   wb_inst,
  output logic [XLEN-1:0]               wb_data,
  output logic [4:0]                    wb_rd_addr,
  output logic                          wb_wr_en,
  output logic [CH_W-1:0]               wb_ch_id
);
  logic [CH_W-1:0] rr_ptr, off, gnt_idx, nxt_ptr;
  logic [CH_W:0] sum;
  logic [NUM_CH-1:0] rot, grant;
  logic any, adv, acc;
  logic [XLEN-1:0] fmt_data;
  logic unused_slot;
  wb_slot_t slot;
  assign any = |ch_valid;
  assign adv = !wb_valid || wb_ready;
  assign acc = adv && !flush && rst_n;
  // rotate so rr_ptr sits at bit 0, pick lowest set bit, rotate the index back
  always_comb begin
    rot = NUM_CH'({ch_valid, ch_valid} >> rr_ptr);
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) off = rot[i] ? CH_W'(i) : off;
    sum = {1'b0, off} + {1'b0, rr_ptr};
    gnt_idx = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH)) : CH_W'(sum);
    nxt_ptr = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    grant = any ? NUM_CH'(1) << gnt_idx : '0;
    ch_ready = acc ? grant : '0;
  end
  riscv_wb_load_fmt #(.XLEN(XLEN)) u_fmt (
    .data    (ch_data[gnt_idx]),
    .funct3  (ch_inst[gnt_idx][14:12]),
    .addr_lo (ch_addr_lo[gnt_idx]),
    .is_load (ch_is_load[gnt_idx]),
    .fmt     (fmt_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid <= 1'b0;
      rr_ptr <= '0;
    end else begin
      wb_valid <= flush ? 1'b0 : adv ? any : wb_valid;
      if (acc && any) rr_ptr <= nxt_ptr;
    end
  // payload is unqualified by reset; wb_valid alone says whether it is meaningful
  always_ff @(posedge clk)
    if (acc)
      slot <= '{pc: XLEN_MAX'(ch_pc[gnt_idx]), inst: ch_inst[gnt_idx], data: XLEN_MAX'(fmt_data),
                rd: ch_rd_addr[gnt_idx], wr_en: ch_rd_addr[gnt_idx] != 5'd0,
                ch_id: CH_ID_MAX_W'(gnt_idx)};
  assign wb_pc = slot.pc[XLEN-1:0];
  assign wb_inst = slot.inst;
  assign wb_data = slot.data[XLEN-1:0];
  assign wb_rd_addr = slot.rd;
  assign wb_wr_en = slot.wr_en;
  assign wb_ch_id = slot.ch_id[CH_W-1:0];
  assign unused_slot = ^slot;
endmodule
